// File: rtl/uart_dbg_cmd_seq.sv
// -----------------------------------------------------------------------------
// uart_dbg_cmd_seq
//
// Debug command sequencer sitting between a byte UART and a simple register bus.
// Decodes write (0x57 ADDR D3 D2 D1 D0) and read (0x52 ADDR) commands, performs
// the register access, and returns a response over the UART transmitter:
//   write ok   -> 0x4B
//   read ok    -> rdata[31:24], [23:16], [15:8], [7:0]
//   bad input  -> 0x45  (bad opcode, parity/overflow, inter-byte timeout)
//   bus stall  -> 0x54  (no reg_ack within ACK_TIMEOUT cycles)
//
// Handshakes: rx_valid and tx_valid are single-cycle strobes with no back
// pressure; tx_valid is only issued while tx_busy is low. reg_wr/reg_rd are
// levels held from state entry through the reg_ack cycle, then dropped.
//
// Ports:
//   core_clk, core_rst_n       clock, asynchronous active-low reset
//   rx_data/rx_valid           received byte strobe
//   rx_overflow, rx_parity_err UART receive error flags
//   tx_data/tx_valid, tx_busy  transmit strobe and transmitter busy flag
//   reg_addr/wdata/wr/rd       register bus request
//   reg_rdata/reg_ack          register bus completion
//   seq_state                  FSM state code (debug)
//   err_count                  saturating count of 0x45/0x54 responses
// -----------------------------------------------------------------------------
module uart_dbg_cmd_seq #(
    parameter int BYTE_TIMEOUT = 2500000,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_overflow,
    input  logic        rx_parity_err,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_busy,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_wr,
    output logic        reg_rd,
    input  logic [31:0] reg_rdata,
    input  logic        reg_ack,
    output logic [3:0]  seq_state,
    output logic [7:0]  err_count
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_GET_ADDR = 4'd1,
        S_GET_DATA = 4'd2,
        S_BUS_WR   = 4'd3,
        S_BUS_RD   = 4'd4,
        S_LOAD_RSP = 4'd5,
        S_SEND     = 4'd6,
        S_WAIT_TX  = 4'd7
    } state_t;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;
    localparam logic [7:0] RSP_TMO = 8'h54;

    // One counter serves both the inter-byte and the bus-ack timeouts; it is
    // cleared on every state change so the two uses never overlap.
    localparam int MAX_TMO = (BYTE_TIMEOUT > ACK_TIMEOUT) ? BYTE_TIMEOUT : ACK_TIMEOUT;
    localparam int CW      = $clog2(MAX_TMO + 1);
    localparam logic [CW-1:0] BYTE_LAST = CW'(BYTE_TIMEOUT - 1);
    localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic          is_write;
    logic [1:0]    data_cnt;
    logic [CW-1:0] tmo_cnt;
    logic [31:0]   rsp_shift;
    logic [2:0]    rsp_cnt;
    logic [1:0]    wait_cnt;

    logic          rx_abort;
    logic          byte_tmo;
    logic          ack_tmo;
    logic          op_take;
    logic          addr_take;
    logic          data_take;
    logic          err_rsp;
    logic          rsp_load;
    logic [31:0]   rsp_val;
    logic [2:0]    rsp_num;
    logic          err_inc;
    logic          tmo_clr;
    logic          tmo_run;

    assign rx_abort = rx_overflow || (rx_valid && rx_parity_err);
    assign byte_tmo = (tmo_cnt == BYTE_LAST);
    assign ack_tmo  = (tmo_cnt == ACK_LAST);

    // State register
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle action decode
    always_comb begin
        state_next = state;
        op_take    = 1'b0;
        addr_take  = 1'b0;
        data_take  = 1'b0;
        err_rsp    = 1'b0;
        rsp_load   = 1'b0;
        rsp_val    = 32'h0;
        rsp_num    = 3'd0;
        err_inc    = 1'b0;

        case (state)
            S_IDLE: begin
                if (rx_abort) begin
                    err_rsp = 1'b1;
                end else if (rx_valid) begin
                    if (rx_data == OP_WR || rx_data == OP_RD) begin
                        op_take    = 1'b1;
                        state_next = S_GET_ADDR;
                    end else begin
                        err_rsp = 1'b1;
                    end
                end
            end
            S_GET_ADDR: begin
                if (rx_abort) begin
                    err_rsp = 1'b1;
                end else if (rx_valid) begin
                    addr_take  = 1'b1;
                    state_next = is_write ? S_GET_DATA : S_BUS_RD;
                end else if (byte_tmo) begin
                    err_rsp = 1'b1;
                end
            end
            S_GET_DATA: begin
                if (rx_abort) begin
                    err_rsp = 1'b1;
                end else if (rx_valid) begin
                    data_take = 1'b1;
                    if (data_cnt == 2'd3) begin
                        state_next = S_BUS_WR;
                    end
                end else if (byte_tmo) begin
                    err_rsp = 1'b1;
                end
            end
            S_BUS_WR, S_BUS_RD: begin
                // An ack in the final allowed cycle still counts as success.
                if (reg_ack) begin
                    rsp_load   = 1'b1;
                    state_next = S_LOAD_RSP;
                    if (state == S_BUS_WR) begin
                        rsp_val = {RSP_OK, 24'h0};
                        rsp_num = 3'd1;
                    end else begin
                        rsp_val = reg_rdata;
                        rsp_num = 3'd4;
                    end
                end else if (ack_tmo) begin
                    rsp_load   = 1'b1;
                    rsp_val    = {RSP_TMO, 24'h0};
                    rsp_num    = 3'd1;
                    err_inc    = 1'b1;
                    state_next = S_LOAD_RSP;
                end
            end
            S_LOAD_RSP: begin
                if (!tx_busy) begin
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                state_next = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                // The first two cycles ignore tx_busy: the UART's flag lags
                // the strobe, so a low value there is stale.
                if (wait_cnt == 2'd2 && !tx_busy) begin
                    state_next = (rsp_cnt != 3'd0) ? S_SEND : S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (err_rsp) begin
            rsp_load   = 1'b1;
            rsp_val    = {RSP_ERR, 24'h0};
            rsp_num    = 3'd1;
            err_inc    = 1'b1;
            state_next = S_LOAD_RSP;
        end
    end

    assign tmo_clr = (state_next != state) || data_take;
    assign tmo_run = (state == S_GET_ADDR) || (state == S_GET_DATA) ||
                     (state == S_BUS_WR)   || (state == S_BUS_RD);

    // Datapath registers
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            is_write  <= 1'b0;
            data_cnt  <= 2'd0;
            tmo_cnt   <= '0;
            rsp_shift <= 32'h0;
            rsp_cnt   <= 3'd0;
            wait_cnt  <= 2'd0;
            reg_addr  <= 8'h00;
            reg_wdata <= 32'h0;
            err_count <= 8'h00;
        end else begin
            if (op_take) begin
                is_write <= (rx_data == OP_WR);
                data_cnt <= 2'd0;
            end
            if (addr_take) begin
                reg_addr <= rx_data;
            end
            if (data_take) begin
                reg_wdata <= {reg_wdata[23:0], rx_data};
                data_cnt  <= data_cnt + 2'd1;
            end

            if (tmo_clr) begin
                tmo_cnt <= '0;
            end else if (tmo_run) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end

            if (rsp_load) begin
                rsp_shift <= rsp_val;
                rsp_cnt   <= rsp_num;
            end else if (state == S_SEND) begin
                rsp_shift <= {rsp_shift[23:0], 8'h00};
                rsp_cnt   <= rsp_cnt - 3'd1;
            end

            if (state == S_SEND) begin
                wait_cnt <= 2'd0;
            end else if (state == S_WAIT_TX && wait_cnt != 2'd2) begin
                wait_cnt <= wait_cnt + 2'd1;
            end

            if (err_inc && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // Outputs decode directly from the state register: requests are high
    // exactly while in the bus states, so they can never overlap.
    assign seq_state = state;
    assign reg_wr    = (state == S_BUS_WR);
    assign reg_rd    = (state == S_BUS_RD);
    assign tx_valid  = (state == S_SEND);
    assign tx_data   = tx_valid ? rsp_shift[31:24] : 8'h00;

endmodule

// File: tb/tb_uart_dbg_cmd_seq.sv
// -----------------------------------------------------------------------------
// tb_uart_dbg_cmd_seq
//
// Command-level model: each driver task knows what bus access and which
// response bytes a command must produce and queues them before issuing the
// bytes. A monitor pops those queues whenever the DUT strobes tx_valid or
// raises a bus request. A UART transmitter model and a register-bus responder
// surround the DUT.
// -----------------------------------------------------------------------------
module tb_uart_dbg_cmd_seq;

  localparam int BT     = 40;
  localparam int ACK_TO = 20;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_overflow;
  logic        rx_parity_err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic [3:0]  seq_state;
  logic [7:0]  err_count;

  uart_dbg_cmd_seq #(
    .BYTE_TIMEOUT (BT),
    .ACK_TIMEOUT  (ACK_TO)
  ) dut (
    .core_clk      (clk),
    .core_rst_n    (rst_n),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_overflow   (rx_overflow),
    .rx_parity_err (rx_parity_err),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_busy       (tx_busy),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_wr        (reg_wr),
    .reg_rd        (reg_rd),
    .reg_rdata     (reg_rdata),
    .reg_ack       (reg_ack),
    .seq_state     (seq_state),
    .err_count     (err_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  int          exp_err = 0;
  logic [7:0]  exp_q[$];
  logic [41:0] exp_bus_q[$];   // {wr, rd, addr, wdata}
  bit          ack_late = 1'b0;
  bit          noise_en = 1'b0;
  logic [31:0] next_rdata = 32'h0;

  task automatic check(input string name, input logic [41:0] act, input logic [41:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // ---------------- monitor ----------------
  logic busy_prev = 1'b0;
  logic req_prev  = 1'b0;
  always @(negedge clk) begin
    logic [7:0]  e;
    logic [41:0] eb;
    if (tx_valid) begin
      check("tx_while_busy", {41'h0, busy_prev}, 42'h0);
      if (exp_q.size() == 0) begin
        fail_now($sformatf("unexpected_tx data=0x%0h", tx_data));
      end else begin
        e = exp_q.pop_front();
        check("tx_data", {34'h0, tx_data}, {34'h0, e});
      end
    end
    if (reg_wr && reg_rd) fail_now("wr_rd_overlap");
    if ((reg_wr || reg_rd) && !req_prev) begin
      if (exp_bus_q.size() == 0) begin
        fail_now("unexpected_bus_request");
      end else begin
        eb = exp_bus_q.pop_front();
        check("bus_request", {reg_wr, reg_rd, reg_addr, (reg_rd ? 32'h0 : reg_wdata)}, eb);
      end
    end
    busy_prev = tx_busy;
    req_prev  = reg_wr || reg_rd;
  end

  // ---------------- UART transmitter model ----------------
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_valid) begin
        @(posedge clk); #1 tx_busy = 1'b1;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1 tx_busy = 1'b0;
      end else if (noise_en && $urandom_range(0, 15) == 0) begin
        @(posedge clk); #1;
        if (!tx_valid) begin
          tx_busy = 1'b1;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1 tx_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- register bus responder ----------------
  initial begin
    int n;
    bit going;
    reg_ack   = 1'b0;
    reg_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (reg_wr || reg_rd) begin
        if (!ack_late) begin
          repeat ($urandom_range(0, 6)) @(posedge clk);
          @(posedge clk); #1 reg_ack = 1'b1; reg_rdata = next_rdata;
          @(posedge clk); #1 reg_ack = 1'b0; reg_rdata = 32'h0;
        end else begin
          n = 1;
          going = 1'b1;
          while (going) begin
            @(negedge clk);
            if ((reg_wr || reg_rd) && n < 1000) n++;
            else going = 1'b0;
          end
          check("ack_timeout_cycles", 42'(n), 42'(ACK_TO));
          // stray completion long after the request was abandoned
          repeat (2) @(posedge clk);
          #1 reg_ack = 1'b1; reg_rdata = $urandom;
          @(posedge clk); #1 reg_ack = 1'b0; reg_rdata = 32'h0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit par);
    repeat ($urandom_range(0, 4)) @(posedge clk);
    @(posedge clk); #1 rx_data = b; rx_valid = 1'b1; rx_parity_err = par;
    @(posedge clk); #1 rx_data = 8'h00; rx_valid = 1'b0; rx_parity_err = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (seq_state == 4'd0 && exp_q.size() == 0 && exp_bus_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      fail_now({tag, "_idle_timeout"});
      exp_q.delete();
      exp_bus_q.delete();
    end else begin
      check({tag, "_err_count"}, {34'h0, err_count}, 42'(exp_err));
    end
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data);
    exp_bus_q.push_back({1'b1, 1'b0, addr, data});
    exp_q.push_back(8'h4B);
    send_byte(8'h57, 1'b0);
    send_byte(addr, 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(data[i*8 +: 8], 1'b0);
    wait_idle("write");
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [31:0] rdata);
    next_rdata = rdata;
    exp_bus_q.push_back({1'b0, 1'b1, addr, 32'h0});
    if (!ack_late) begin
      for (int i = 3; i >= 0; i--) exp_q.push_back(rdata[i*8 +: 8]);
    end else begin
      exp_q.push_back(8'h54);
      exp_err = sat_inc(exp_err);
    end
    send_byte(8'h52, 1'b0);
    send_byte(addr, 1'b0);
    wait_idle("read");
  endtask

  task automatic do_bad_op(input logic [7:0] op);
    exp_q.push_back(8'h45);
    exp_err = sat_inc(exp_err);
    send_byte(op, 1'b0);
    wait_idle("bad_op");
  endtask

  // parity error lands on byte index pos of a write command (0 = opcode)
  task automatic do_parity(input logic [7:0] addr, input logic [31:0] data, input int pos);
    logic [7:0] b [6];
    b[0] = 8'h57; b[1] = addr;
    b[2] = data[31:24]; b[3] = data[23:16]; b[4] = data[15:8]; b[5] = data[7:0];
    exp_q.push_back(8'h45);
    exp_err = sat_inc(exp_err);
    for (int i = 0; i <= pos; i++) send_byte(b[i], (i == pos));
    wait_idle("parity");
  endtask

  task automatic do_overflow(input logic [7:0] op);
    exp_q.push_back(8'h45);
    exp_err = sat_inc(exp_err);
    send_byte(op, 1'b0);
    @(posedge clk); #1 rx_overflow = 1'b1;
    @(posedge clk); #1 rx_overflow = 1'b0;
    wait_idle("overflow");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"},  {41'h0, tx_valid}, 42'h0);
    check({tag, "_tx_data"},   {34'h0, tx_data}, 42'h0);
    check({tag, "_reg_wr"},    {41'h0, reg_wr}, 42'h0);
    check({tag, "_reg_rd"},    {41'h0, reg_rd}, 42'h0);
    check({tag, "_reg_addr"},  {34'h0, reg_addr}, 42'h0);
    check({tag, "_reg_wdata"}, {10'h0, reg_wdata}, 42'h0);
    check({tag, "_err_count"}, {34'h0, err_count}, 42'h0);
    check({tag, "_seq_state"}, {38'h0, seq_state}, 42'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] op;
    bit got;
    rst_n = 1'b0;
    rx_data = 8'h00; rx_valid = 1'b0; rx_overflow = 1'b0; rx_parity_err = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // basic write and read
    do_write(8'h10, 32'hDEADBEEF);
    do_read(8'h20, 32'h12345678);

    // errors: bad opcode, then parity on the D2 byte of a write
    do_bad_op(8'h33);
    do_parity(8'h10, 32'hCAFEF00D, 3);

    // bus read never acknowledged in time, then a stray ack
    ack_late = 1'b1;
    do_read(8'h44, 32'h0);
    ack_late = 1'b0;

    // stall mid-command past the inter-byte timeout, then a clean read
    exp_q.push_back(8'h45);
    exp_err = sat_inc(exp_err);
    send_byte(8'h57, 1'b0);
    send_byte(8'h10, 1'b0);
    wait_idle("byte_timeout");
    do_read(8'h00, 32'hA5C3_0F96);

    // reset in the middle of a 4-byte read response
    next_rdata = 32'h8899AABB;
    exp_bus_q.push_back({1'b0, 1'b1, 8'h20, 32'h0});
    for (int i = 3; i >= 0; i--) exp_q.push_back(next_rdata[i*8 +: 8]);
    send_byte(8'h52, 1'b0);
    send_byte(8'h20, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (exp_q.size() <= 2) got = 1'b1;
    end
    if (!got) fail_now("mid_rsp_wait_timeout");
    @(posedge clk); #1 rst_n = 1'b0;
    exp_q.delete();
    exp_bus_q.delete();
    exp_err = 0;
    @(negedge clk);
    check_reset_outputs("mid_rsp_reset");
    repeat (4) @(negedge clk);
    check("mid_rsp_reset_hold_tx", {41'h0, tx_valid}, 42'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_read(8'h21, 32'h0BAD_F00D);

    // randomized command mix with background transmitter busy noise
    noise_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 4))
        0: do_write($urandom, $urandom);
        1: do_read($urandom, $urandom);
        2: begin
          op = $urandom;
          if (op == 8'h57 || op == 8'h52) op = op ^ 8'h01;
          do_bad_op(op);
        end
        3: do_parity($urandom, $urandom, $urandom_range(0, 5));
        default: do_overflow(($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52);
      endcase
    end
    noise_en = 1'b0;

    // drive err_count into saturation
    for (int k = 0; k < 260; k++) do_bad_op(8'h00);
    check("err_count_saturated", {34'h0, err_count}, 42'hFF);
    do_write(8'h7F, 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_500_000;
    fail_now("watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
